// File: rtl/apb_timer_multi_pkg.sv
// Shared register map, field positions and tick-source encoding for the
// multi-channel APB timer.
package apb_timer_multi_pkg;

    localparam logic [1:0] REG_CFG  = 2'd0;
    localparam logic [1:0] REG_CNT  = 2'd1;
    localparam logic [1:0] REG_CMP  = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;

    localparam int unsigned CFG_EN_BIT       = 0;
    localparam int unsigned CFG_ONESHOT_BIT  = 1;
    localparam int unsigned CFG_SRC_LSB      = 2;
    localparam int unsigned CFG_PRESC_EN_BIT = 4;
    localparam int unsigned CFG_IRQ_EN_BIT   = 5;
    localparam int unsigned CFG_CLR_BIT      = 6;
    localparam int unsigned CFG_PRESC_LSB    = 8;

    localparam int unsigned STAT_PEND_BIT = 0;
    localparam int unsigned STAT_RUN_BIT  = 1;

    typedef enum logic [1:0] {
        SRC_CLK  = 2'd0,
        SRC_REF  = 2'd1,
        SRC_EVT  = 2'd2,
        SRC_NONE = 2'd3
    } src_e;

endpackage

// File: rtl/apb_timer_multi_chan.sv
// One timer channel: config/count/compare registers, tick-source select,
// prescaler, compare match and pending-interrupt flag.
module apb_timer_multi_chan #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned PRESC_W = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_i,
    input  logic [1:0]  reg_i,
    input  logic [31:0] wdata_i,
    input  logic        ref_tick_i,
    input  logic        event_i,
    input  logic        stoptimer_i,
    output logic [31:0] rdata_o,
    output logic        irq_o,
    output logic        en_o
);
    import apb_timer_multi_pkg::*;

    logic               en_q, en_d;
    logic               oneshot_q, oneshot_d;
    src_e               src_q, src_d;
    logic               presc_en_q, presc_en_d;
    logic               irq_en_q, irq_en_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cmp_q, cmp_d;
    logic               pend_q, pend_d;

    logic cfg_wr, cnt_wr, cmp_wr, stat_wr, clr;
    logic src_hit, raw_tick, ptick, match;
    logic unused_wdata;

    assign cfg_wr  = wr_i && (reg_i == REG_CFG);
    assign cnt_wr  = wr_i && (reg_i == REG_CNT);
    assign cmp_wr  = wr_i && (reg_i == REG_CMP);
    assign stat_wr = wr_i && (reg_i == REG_STAT);
    assign clr     = cfg_wr && wdata_i[CFG_CLR_BIT];
    assign unused_wdata = ^wdata_i;

    always_comb begin
        src_hit = 1'b0;
        case (src_q)
            SRC_CLK:  src_hit = 1'b1;
            SRC_REF:  src_hit = ref_tick_i;
            SRC_EVT:  src_hit = event_i;
            default:  src_hit = 1'b0;
        endcase
    end

    // A CFG write that clears EN already blocks the tick of its own cycle.
    assign raw_tick = src_hit && en_q && !(cfg_wr && !wdata_i[CFG_EN_BIT]) && !stoptimer_i;

    always_comb begin
        ptick  = 1'b0;
        pcnt_d = pcnt_q;
        if (raw_tick) begin
            if (!presc_en_q) begin
                ptick = 1'b1;
            end else if (pcnt_q == presc_q) begin
                ptick  = 1'b1;
                pcnt_d = '0;
            end else begin
                pcnt_d = pcnt_q + PRESC_W'(1);
            end
        end
        // Every CFG write rewrites PRESC (and may carry CLR): restart the divider.
        if (cfg_wr) begin
            pcnt_d = '0;
        end
    end

    assign match = ptick && !clr && !cnt_wr && (cnt_q == cmp_q);

    always_comb begin
        en_d       = en_q;
        oneshot_d  = oneshot_q;
        src_d      = src_q;
        presc_en_d = presc_en_q;
        irq_en_d   = irq_en_q;
        presc_d    = presc_q;
        cmp_d      = cmp_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;

        if (cfg_wr) begin
            en_d       = wdata_i[CFG_EN_BIT];
            oneshot_d  = wdata_i[CFG_ONESHOT_BIT];
            src_d      = src_e'(wdata_i[CFG_SRC_LSB +: 2]);
            presc_en_d = wdata_i[CFG_PRESC_EN_BIT];
            irq_en_d   = wdata_i[CFG_IRQ_EN_BIT];
            presc_d    = wdata_i[CFG_PRESC_LSB +: PRESC_W];
        end
        if (cmp_wr) begin
            cmp_d = wdata_i[CNT_W-1:0];
        end

        if (clr) begin
            cnt_d = '0;
        end else if (cnt_wr) begin
            cnt_d = wdata_i[CNT_W-1:0];
        end else if (ptick) begin
            cnt_d = match ? '0 : cnt_q + CNT_W'(1);
        end

        if (stat_wr && wdata_i[STAT_PEND_BIT]) begin
            pend_d = 1'b0;
        end
        if (match) begin
            pend_d = 1'b1;
            if (oneshot_q) begin
                en_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q       <= 1'b0;
            oneshot_q  <= 1'b0;
            src_q      <= SRC_CLK;
            presc_en_q <= 1'b0;
            irq_en_q   <= 1'b0;
            presc_q    <= '0;
            pcnt_q     <= '0;
            cnt_q      <= '0;
            cmp_q      <= '0;
            pend_q     <= 1'b0;
        end else begin
            en_q       <= en_d;
            oneshot_q  <= oneshot_d;
            src_q      <= src_d;
            presc_en_q <= presc_en_d;
            irq_en_q   <= irq_en_d;
            presc_q    <= presc_d;
            pcnt_q     <= pcnt_d;
            cnt_q      <= cnt_d;
            cmp_q      <= cmp_d;
            pend_q     <= pend_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (reg_i)
            REG_CFG: begin
                rdata_o[CFG_EN_BIT]                 = en_q;
                rdata_o[CFG_ONESHOT_BIT]            = oneshot_q;
                rdata_o[CFG_SRC_LSB +: 2]           = src_q;
                rdata_o[CFG_PRESC_EN_BIT]           = presc_en_q;
                rdata_o[CFG_IRQ_EN_BIT]             = irq_en_q;
                rdata_o[CFG_PRESC_LSB +: PRESC_W]   = presc_q;
            end
            REG_CNT:  rdata_o[CNT_W-1:0] = cnt_q;
            REG_CMP:  rdata_o[CNT_W-1:0] = cmp_q;
            REG_STAT: begin
                rdata_o[STAT_PEND_BIT] = pend_q;
                rdata_o[STAT_RUN_BIT]  = en_q;
            end
        endcase
    end

    assign irq_o = pend_q && irq_en_q;
    assign en_o  = en_q;

endmodule

// File: rtl/apb_timer_multi.sv
// Multi-channel APB timer top: zero-wait APB decode, per-channel write
// strobes, read mux and out-of-range error response.
module apb_timer_multi #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned PRESC_W = 8,
    parameter int unsigned ADDR_W  = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic              ref_tick_i,
    input  logic [NUM_CH-1:0] event_i,
    input  logic              stoptimer_i,
    output logic [NUM_CH-1:0] irq_o,
    output logic              busy_o
);
    import apb_timer_multi_pkg::*;

    // One spare bit so NUM_CH=16 still compares correctly against a 4-bit index.
    localparam int unsigned IDX_W = ADDR_W - 3;

    logic [IDX_W-1:0]  ch_idx;
    logic              ch_valid;
    logic              access;
    logic              wr;
    logic [31:0]       ch_rdata [NUM_CH];
    logic [NUM_CH-1:0] ch_en;
    logic [31:0]       rd_mux;
    logic              unused_addr;

    assign ch_idx      = {1'b0, PADDR[ADDR_W-1:4]};
    assign ch_valid    = ch_idx < IDX_W'(NUM_CH);
    assign access      = PSEL && PENABLE;
    assign wr          = access && PWRITE && ch_valid;
    assign unused_addr = ^PADDR[1:0];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        apb_timer_multi_chan #(
            .CNT_W   (CNT_W),
            .PRESC_W (PRESC_W)
        ) u_chan (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .wr_i        (wr && (ch_idx == IDX_W'(c))),
            .reg_i       (PADDR[3:2]),
            .wdata_i     (PWDATA),
            .ref_tick_i  (ref_tick_i),
            .event_i     (event_i[c]),
            .stoptimer_i (stoptimer_i),
            .rdata_o     (ch_rdata[c]),
            .irq_o       (irq_o[c]),
            .en_o        (ch_en[c])
        );
    end

    always_comb begin
        rd_mux = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch_idx == IDX_W'(c)) begin
                rd_mux = ch_rdata[c];
            end
        end
    end

    assign PRDATA  = (access && !PWRITE && ch_valid) ? rd_mux : '0;
    assign PSLVERR = access && !ch_valid;
    assign PREADY  = 1'b1;
    assign busy_o  = |ch_en;

endmodule
